// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - two-source round-robin arbiter for the six-digit display bank
//
// Purpose:
//   Shares the seven-segment display bank between the CPU PIO words (source 0)
//   and a local overlay (source 1). Arbitration is round-robin with a bounded
//   hold time. Every ownership change passes through exactly one gap cycle.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous reset, active-high
//   req          in   2   level-sensitive request per source
//   digits_0     in  24   source 0 digit codes, [23:20]=digit 5 .. [3:0]=digit 0
//   digits_1     in  24   source 1 digit codes, same packing
//   grant        out  2   one-hot owner, 00 = no owner
//   display_data out 24   registered digit codes to the display drivers
//   active       out  1   high while a source owns the display
//   preempted    out  2   one-cycle pulse when that source loses the grant by timeout
module display_arbiter #(
   parameter int unsigned MAX_HOLD   = 50000000,
   parameter logic [23:0] BLANK_WORD = 24'h000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [23:0] digits_0,
   input  logic [23:0] digits_1,
   output logic [1:0]  grant,
   output logic [23:0] display_data,
   output logic        active,
   output logic [1:0]  preempted
);

   localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   // Count value at which a waiting rival forces the owner out.
   localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [HCW-1:0]  hold_q, hold_d;
   logic [1:0]      grant_q, grant_d;
   logic [23:0]     data_q, data_d;
   logic            active_q, active_d;
   logic [1:0]      pre_q, pre_d;
   logic            rival;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      data_d  = data_q;
      pre_d   = 2'b00;
      rival   = ~owner_q;

      case (state_q)
         IDLE, GAP: begin
            // The gap cycle keeps the previous word so the digits never flash blank.
            if (state_q == IDLE) begin
               data_d = BLANK_WORD;
            end
            state_d = IDLE;
            hold_d  = '0;
            if (req != 2'b00) begin
               state_d = OWN;
               // On a tie the source that did not own last wins.
               owner_d = (req == 2'b11) ? ~last_q : req[1];
            end
         end
         OWN: begin
            data_d = owner_q ? digits_1 : digits_0;
            if (!req[owner_q]) begin
               // Release wins over a simultaneous timeout: no preempted pulse.
               state_d = GAP;
               last_d  = owner_q;
               hold_d  = '0;
            end else if (req[rival]) begin
               if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                  state_d        = GAP;
                  last_d         = owner_q;
                  hold_d         = '0;
                  pre_d[owner_q] = 1'b1;
               end else if (MAX_HOLD != 0) begin
                  hold_d = hold_q + 1'b1;
               end
            end else begin
               hold_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      grant_d  = (state_d == OWN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
      active_d = (state_d == OWN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         hold_q   <= '0;
         grant_q  <= 2'b00;
         data_q   <= BLANK_WORD;
         active_q <= 1'b0;
         pre_q    <= 2'b00;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         hold_q   <= hold_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         active_q <= active_d;
         pre_q    <= pre_d;
      end
   end

   assign grant        = grant_q;
   assign display_data = data_q;
   assign active       = active_q;
   assign preempted    = pre_q;

endmodule
